// File: rtl/seg7_scan_display_pkg.sv
// Shared constants and types for the 4-digit multiplexed 7-segment display sink.
// All segment patterns are active low: {g,f,e,d,c,b,a}.
package seg7_scan_display_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'hF;

  typedef logic [1:0] dig_idx_t;

  // Frame snapshot: everything the scan needs stays frozen for a whole frame.
  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  point;
    logic [3:0]  blink;
    logic        ph;
  } snap_t;

endpackage

// File: rtl/seg7_scan_display_hex_decode.sv
// Combinational hex-to-7-segment decoder, full 0-F font, active-low output.
module seg7_hex_decode
  import seg7_scan_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = SEG_8;
    unique case (nibble_i)
      4'h0: seg_n_o = SEG_0;
      4'h1: seg_n_o = SEG_1;
      4'h2: seg_n_o = SEG_2;
      4'h3: seg_n_o = SEG_3;
      4'h4: seg_n_o = SEG_4;
      4'h5: seg_n_o = SEG_5;
      4'h6: seg_n_o = SEG_6;
      4'h7: seg_n_o = SEG_7;
      4'h8: seg_n_o = SEG_8;
      4'h9: seg_n_o = SEG_9;
      4'hA: seg_n_o = SEG_A;
      4'hB: seg_n_o = SEG_B;
      4'hC: seg_n_o = SEG_C;
      4'hD: seg_n_o = SEG_D;
      4'hE: seg_n_o = SEG_E;
      4'hF: seg_n_o = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed driver for a common-anode 4-digit 7-segment display with
// per-digit decimal point and blink; inputs are snapshotted once per frame.
module seg7_scan_display
  import seg7_scan_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned DEAD_CYC  = 2,
  parameter int unsigned BLINK_DIV = 12500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] disp_data,
  input  logic [3:0]  s_point,
  input  logic [3:0]  t_blink,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [ScanW-1:0]  ScanMax  = ScanW'(SCAN_DIV - 1);
  localparam logic [ScanW-1:0]  DeadCyc  = ScanW'(DEAD_CYC);
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_DIV - 1);

  logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
  dig_idx_t          dig_idx_q, dig_idx_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_ph_q, blink_ph_d;
  logic              load_q, load_d;
  snap_t             snap_q, snap_d;
  logic [3:0]        an_q, an_d;
  logic [7:0]        seg_q, seg_d;

  logic              scan_wrap;
  logic              blink_wrap;
  logic              frame_end;
  logic              in_dead;
  logic              blanked;
  logic [3:0]        cur_nibble;
  logic [6:0]        cur_seg_n;

  // ---------------------------------------------------------------------------
  // Counters and snapshot next state
  // ---------------------------------------------------------------------------
  assign scan_wrap  = (scan_cnt_q == ScanMax);
  assign blink_wrap = (blink_cnt_q == BlinkMax);
  assign frame_end  = scan_wrap && (dig_idx_q == dig_idx_t'(NUM_DIGITS - 1));

  always_comb begin
    scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    dig_idx_d   = scan_wrap ? dig_idx_q + 1'b1 : dig_idx_q;
    blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    blink_ph_d  = blink_wrap ? ~blink_ph_q : blink_ph_q;
    load_d      = 1'b0;
    snap_d      = snap_q;
    // Load at the last cycle of digit 3 so the next frame starts on fresh data.
    if (load_q || frame_end) begin
      snap_d.data  = disp_data;
      snap_d.point = s_point;
      snap_d.blink = t_blink;
      snap_d.ph    = blink_ph_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Output next state, one cycle behind (dig_idx, scan_cnt)
  // ---------------------------------------------------------------------------
  assign cur_nibble = snap_q.data[{dig_idx_q, 2'b00} +: 4];
  assign in_dead    = (scan_cnt_q < DeadCyc);
  assign blanked    = snap_q.blink[dig_idx_q] && snap_q.ph;

  seg7_hex_decode u_hex_decode (
    .nibble_i (cur_nibble),
    .seg_n_o  (cur_seg_n)
  );

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (!in_dead && !blanked) begin
      an_d  = ~(4'b0001 << dig_idx_q);
      seg_d = {~snap_q.point[dig_idx_q], cur_seg_n};
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_q  <= '0;
      dig_idx_q   <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      load_q      <= 1'b1;
      snap_q      <= '0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_OFF;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      dig_idx_q   <= dig_idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      load_q      <= load_d;
      snap_q      <= snap_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule
